// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage 8-bit pipeline: register-file geometry and
// hazard-sequencer state encoding.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned DATA_W     = 8;

  typedef logic [1:0] state_t;

  localparam state_t RUN      = 2'd0;
  localparam state_t MEM_WAIT = 2'd1;
  localparam state_t HALT     = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes and
// data-memory waits with a timeout watchdog, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          R0_ZERO     = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  ex_memRd,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_tkn,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  cnt_clr,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic memstall;
  logic lu;
  logic rs1_hit;
  logic rs2_hit;
  logic r0_block;

  assign memstall = mem_req & ~mem_ready & (state_q != HALT);
  assign rs1_hit  = id_use1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_use2 & (id_rs2 == ex_rd);
  assign r0_block = R0_ZERO & (ex_rd == '0);
  assign lu       = ex_memRd & (rs1_hit | rs2_hit) & ~r0_block;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      // Everything frozen while reset is held.
    end else if (state_q == HALT) begin
      halted = 1'b1;
    end else if (memstall) begin
      // Only WB advances so its instruction retires once; a bubble follows it.
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (branch_tkn) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!memstall) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (~pc_en),
    .count(stall_cnt)
  );

endmodule
